// File: rtl/debounce_bank_pkg.sv
// Shared timing constants and the per-channel output bundle for the debounce bank.
package debounce_bank_pkg;

  localparam int CLK_HZ        = 100_000_000;
  localparam int DEBOUNCE_10MS = CLK_HZ / 100;
  localparam int HOLD_500MS    = CLK_HZ / 2;
  localparam int REPEAT_100MS  = CLK_HZ / 10;

  localparam int DEF_N     = 8;
  localparam int DEF_NSYNC = 2;
  localparam int DEF_CW    = 20;
  localparam int DEF_HW    = 26;

  typedef struct packed {
    logic clean;
    logic rise;
    logic fall;
    logic held;
    logic rpt;
  } chan_out_t;

endpackage

// File: rtl/debounce_bank_if.sv
// Bus bundle between raw switch pins and the conditioned outputs of the debounce bank.
interface debounce_bank_if #(
  parameter int N = 8
);
  // No handshake: noisy is sampled every clock, all outputs are registered levels or 1-cycle strobes.
  logic [N-1:0] noisy;
  logic [N-1:0] clean;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] held;
  logic [N-1:0] rpt;

  modport master (output noisy, input clean, rise, fall, held, rpt);
  modport slave  (input noisy, output clean, rise, fall, held, rpt);
endinterface

// File: rtl/debounce_bank_chan.sv
// One switch channel: synchroniser, counter debounce, edge pulses, long-press and auto-repeat.
module debounce_chan
  import debounce_bank_pkg::*;
#(
  parameter int NSYNC  = 2,
  parameter int DELAY  = 4,
  parameter int CW     = 3,
  parameter int HOLD   = 20,
  parameter int REPEAT = 5,
  parameter int HW     = 5
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      i_noisy,
  output chan_out_t o_out
);

  // cand acts as the last synchroniser stage, so the chain itself is one flop shorter.
  logic [NSYNC-2:0] r_sync;
  logic             r_cand;
  logic [CW-1:0]    r_cnt;
  logic [HW-1:0]    r_hc;
  logic [HW-1:0]    r_rc;
  chan_out_t        r_out;

  logic          w_s;
  logic          w_stable;
  logic          w_commit;
  logic          w_rise;
  logic          w_fall;
  logic [HW-1:0] w_hc_next;
  logic          w_held_next;
  logic          w_rc_hit;
  logic [HW-1:0] w_rc_next;
  logic          w_rpt;

  assign w_s = r_sync[NSYNC-2];

  always_comb begin
    w_stable    = (w_s == r_cand);
    w_commit    = w_stable && (r_cnt == CW'(DELAY));
    w_rise      = w_commit && r_cand && !r_out.clean;
    w_fall      = w_commit && !r_cand && r_out.clean;

    w_hc_next   = r_hc;
    if (!r_out.clean || w_fall) begin
      w_hc_next = '0;
    end else if (r_hc != HW'(HOLD)) begin
      w_hc_next = r_hc + HW'(1);
    end
    w_held_next = !w_fall && (r_out.held || (r_out.clean && (w_hc_next == HW'(HOLD))));

    w_rc_hit    = r_out.held && (r_rc == HW'(REPEAT - 1));
    w_rc_next   = r_rc + HW'(1);
    if (!r_out.held || w_fall || w_rc_hit) begin
      w_rc_next = '0;
    end

    // A release edge kills any strobe that would otherwise land on it.
    w_rpt = w_rise || (!r_out.held && w_held_next) || (w_rc_hit && !w_fall);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= '0;
      r_cand <= 1'b0;
      r_cnt  <= '0;
      r_hc   <= '0;
      r_rc   <= '0;
      r_out  <= '0;
    end else begin
      r_sync[0] <= i_noisy;
      for (int i = 1; i < NSYNC - 1; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      if (!w_stable) begin
        r_cand <= w_s;
        r_cnt  <= '0;
      end else if (r_cnt != CW'(DELAY)) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_commit) begin
        r_out.clean <= r_cand;
      end
      r_out.rise <= w_rise;
      r_out.fall <= w_fall;
      r_out.held <= w_held_next;
      r_out.rpt  <= w_rpt;
      r_hc       <= w_hc_next;
      r_rc       <= w_rc_next;
    end
  end

  assign o_out = r_out;

endmodule

// File: rtl/debounce_bank.sv
// N independent switch conditioners; this level only fans the per-channel buses.
module debounce_bank
  import debounce_bank_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int NSYNC  = DEF_NSYNC,
  parameter int DELAY  = DEBOUNCE_10MS,
  parameter int CW     = DEF_CW,
  parameter int HOLD   = HOLD_500MS,
  parameter int REPEAT = REPEAT_100MS,
  parameter int HW     = DEF_HW
) (
  input  logic            clock,
  input  logic            reset,
  debounce_bank_if.slave  bus
);

  chan_out_t    w_out [N];
  logic [N-1:0] w_clean;
  logic [N-1:0] w_rise;
  logic [N-1:0] w_fall;
  logic [N-1:0] w_held;
  logic [N-1:0] w_rpt;

  for (genvar g = 0; g < N; g++) begin : g_chan
    debounce_chan #(
      .NSYNC (NSYNC),
      .DELAY (DELAY),
      .CW    (CW),
      .HOLD  (HOLD),
      .REPEAT(REPEAT),
      .HW    (HW)
    ) u_chan (
      .clock  (clock),
      .reset  (reset),
      .i_noisy(bus.noisy[g]),
      .o_out  (w_out[g])
    );
    assign w_clean[g] = w_out[g].clean;
    assign w_rise[g]  = w_out[g].rise;
    assign w_fall[g]  = w_out[g].fall;
    assign w_held[g]  = w_out[g].held;
    assign w_rpt[g]   = w_out[g].rpt;
  end

  assign bus.clean = w_clean;
  assign bus.rise  = w_rise;
  assign bus.fall  = w_fall;
  assign bus.held  = w_held;
  assign bus.rpt   = w_rpt;

endmodule
